// File: rtl/pr_request_poller.sv
// rtl/pr_request_poller.sv - AXI-lite master draining the PR request queue
module pr_request_poller #(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         HOLDOFF_CYCLES = 4,
    parameter logic [3:0] REQ_RADDR      = 4'h0,
    parameter logic [1:0] ACK_WADDR      = 2'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pr_request_pending,
    output logic [3:0]  m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [1:0]  m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] req_word,
    output logic        req_valid,
    input  logic        req_ready,
    input  logic        done_valid,
    input  logic        done_error,
    output logic        busy,
    output logic [15:0] timeout_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HOLDOFF_LOAD = HW'(HOLDOFF_CYCLES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_REQ  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_WR   = 3'd5;
    localparam logic [2:0] S_B    = 3'd6;

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [TW-1:0] timer;
    logic [HW-1:0] holdoff;
    logic          aw_done;
    logic          w_done;
    logic          aw_hs;
    logic          w_hs;
    logic          timer_expired;

    // Channel valids/readies are plain decodes of the registered state.
    assign m_axi_araddr  = REQ_RADDR;
    assign m_axi_awaddr  = ACK_WADDR;
    assign m_axi_arvalid = (state == S_AR);
    assign m_axi_rready  = (state == S_R);
    assign req_valid     = (state == S_REQ);
    assign m_axi_awvalid = (state == S_WR) && !aw_done;
    assign m_axi_wvalid  = (state == S_WR) && !w_done;
    assign m_axi_bready  = (state == S_B);

    assign aw_hs         = m_axi_awvalid && m_axi_awready;
    assign w_hs          = m_axi_wvalid && m_axi_wready;
    assign timer_expired = (timer == TIMER_LAST);

    // Next-state selection; done_valid only matters while waiting.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (pr_request_pending && (holdoff == '0)) state_next = S_AR;
            S_AR:   if (m_axi_arready) state_next = S_R;
            S_R:    if (m_axi_rvalid) state_next = S_REQ;
            S_REQ:  if (req_ready) state_next = S_WAIT;
            S_WAIT: if (done_valid || timer_expired) state_next = S_WR;
            S_WR:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = S_B;
            S_B:    if (m_axi_bvalid) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register with busy registered alongside it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != S_IDLE);
        end
    end

    // Wait timer counts only in WAIT and restarts from zero on every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (state == S_WAIT) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end

    // Holdoff lets the core's pending flag catch up with our acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            holdoff <= '0;
        end else if ((state == S_B) && m_axi_bvalid) begin
            holdoff <= HOLDOFF_LOAD;
        end else if ((state == S_IDLE) && (holdoff != '0)) begin
            holdoff <= holdoff - 1'b1;
        end
    end

    // AW and W retire independently; the flags clear outside WR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == S_WR) begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end else begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end
    end

    // Request capture, completion word and timeout statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_word      <= '0;
            m_axi_wdata   <= '0;
            timeout_count <= '0;
        end else begin
            if ((state == S_R) && m_axi_rvalid) begin
                req_word <= m_axi_rdata;
            end
            if ((state == S_WAIT) && (done_valid || timer_expired)) begin
                // A done arriving on the expiry cycle takes precedence.
                m_axi_wdata <= {done_valid ? done_error : 1'b1, req_word[30:0]};
                if (!done_valid && (timeout_count != 16'hFFFF)) begin
                    timeout_count <= timeout_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pr_request_poller.sv
// tb/tb_pr_request_poller.sv - self-checking bench for pr_request_poller
module tb_pr_request_poller;

    localparam int TO = 16;
    localparam int HO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pr_request_pending;
    logic [3:0]  m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [1:0]  m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] req_word;
    logic        req_valid;
    logic        req_ready;
    logic        done_valid;
    logic        done_error;
    logic        busy;
    logic [15:0] timeout_count;

    pr_request_poller #(
        .TIMEOUT_CYCLES(TO),
        .HOLDOFF_CYCLES(HO),
        .REQ_RADDR(4'h0),
        .ACK_WADDR(2'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pr_request_pending(pr_request_pending),
        .m_axi_araddr(m_axi_araddr),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata),
        .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata),
        .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .req_word(req_word),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .done_valid(done_valid),
        .done_error(done_error),
        .busy(busy),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        int          dd;         // WAIT cycle index of done_valid, -1 = never
        logic        de;
        int          aw_dly;
        int          w_dly;
        logic [31:0] exp_wdata;
        logic [15:0] exp_tc;
        int          exp_ar;     // tick on which arvalid must first appear
        bit          drop_pend;
    } vec_t;

    vec_t        vecs[8];
    vec_t        vpost;
    logic [31:0] sb_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input int id);
        int  ar_tick  = -1;
        int  req_tick = -1;
        int  wr_start = -1;
        int  aw_cnt   = 0;
        int  w_cnt    = 0;
        int  exp_lat;
        bit  r_pushed = 1'b0;
        bit  fin      = 1'b0;
        logic [31:0] exp_w;
        exp_lat = (v.dd < 0) ? TO + 1 : v.dd + 2;
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b1;
        m_axi_rdata   = v.rdata;
        req_ready     = 1'b1;
        m_axi_bvalid  = 1'b1;
        done_error    = v.de;
        for (int u = 1; u <= 120 && !fin; u++) begin
            tick();
            done_valid    = 1'b0;
            m_axi_awready = 1'b0;
            m_axi_wready  = 1'b0;
            if (u == 1 && !busy) done_valid = 1'b1;
            if (m_axi_arvalid && ar_tick < 0) begin
                ar_tick = u;
                chk($sformatf("v%0d ar_tick", id), 32'(u), 32'(v.exp_ar));
                chk($sformatf("v%0d araddr", id), 32'(m_axi_araddr), 32'h0);
                if (v.drop_pend) pr_request_pending = 1'b0;
            end
            if (m_axi_rready && !r_pushed) begin
                sb_q.push_back(v.exp_wdata);
                r_pushed = 1'b1;
            end
            if (req_valid && req_tick < 0) begin
                req_tick = u;
                chk($sformatf("v%0d req_word", id), req_word, v.rdata);
            end
            if ((m_axi_awvalid || m_axi_wvalid) && wr_start < 0) begin
                wr_start = u;
                chk($sformatf("v%0d aw_w_together", id), 32'({m_axi_awvalid, m_axi_wvalid}), 32'h3);
                chk($sformatf("v%0d wr_latency", id), 32'(u - req_tick), 32'(exp_lat));
                chk($sformatf("v%0d awaddr", id), 32'(m_axi_awaddr), 32'h0);
            end
            if (req_tick > 0 && wr_start < 0 && v.dd >= 0 && (u - req_tick - 1) == v.dd)
                done_valid = 1'b1;
            if (wr_start > 0) begin
                m_axi_awready = (u - wr_start >= v.aw_dly);
                m_axi_wready  = (u - wr_start >= v.w_dly);
            end
            if (m_axi_awvalid && m_axi_awready) aw_cnt++;
            if (m_axi_wvalid && m_axi_wready) begin
                w_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL v%0d sb_empty: got W beat %h expected none", id, m_axi_wdata);
                end else begin
                    exp_w = sb_q.pop_front();
                    chk($sformatf("v%0d wdata", id), m_axi_wdata, exp_w);
                end
            end
            if (m_axi_bready) begin
                chk($sformatf("v%0d aw_count", id), 32'(aw_cnt), 32'd1);
                chk($sformatf("v%0d w_count", id), 32'(w_cnt), 32'd1);
                fin = 1'b1;
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL v%0d txn_timeout: got no B phase expected one", id);
        end else begin
            tick();
            chk($sformatf("v%0d busy_after_b", id), 32'(busy), 32'd0);
            chk($sformatf("v%0d bready_after_b", id), 32'(m_axi_bready), 32'd0);
            chk($sformatf("v%0d timeout_count", id), 32'(timeout_count), 32'(v.exp_tc));
        end
        m_axi_bvalid  = 1'b0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        done_valid    = 1'b0;
        done_error    = 1'b0;
    endtask

    initial begin
        int seen;
        //          rdata         dd  de aw w  exp_wdata     tc  ar drop
        vecs[0] = '{32'h0000_0A05,  3, 0, 0, 0, 32'h0000_0A05, 0, 1, 0};
        vecs[1] = '{32'h0000_0A05,  3, 1, 0, 0, 32'h8000_0A05, 0, 5, 0};
        vecs[2] = '{32'h0000_0A05, -1, 0, 0, 0, 32'h8000_0A05, 1, 5, 0};
        vecs[3] = '{32'hA5A5_1234,  0, 0, 0, 2, 32'h25A5_1234, 1, 5, 0};
        vecs[4] = '{32'hFFFF_FFFF,  2, 0, 2, 0, 32'h7FFF_FFFF, 1, 5, 0};
        vecs[5] = '{32'h0000_0001, 15, 0, 1, 1, 32'h0000_0001, 1, 5, 0};
        vecs[6] = '{32'h1357_9BDF, 15, 1, 0, 0, 32'h9357_9BDF, 1, 5, 0};
        vecs[7] = '{32'h7000_0000, -1, 1, 0, 0, 32'hF000_0000, 2, 5, 1};
        vpost   = '{32'h0000_0C3C,  1, 0, 0, 0, 32'h0000_0C3C, 0, 1, 0};

        rst = 1'b0;
        pr_request_pending = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rvalid  = 1'b0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        req_ready     = 1'b0;
        done_valid    = 1'b0;
        done_error    = 1'b0;
        tick();
        tick();
        chk("reset_valids", 32'({m_axi_arvalid, m_axi_rready, req_valid, m_axi_awvalid,
                                 m_axi_wvalid, m_axi_bready, busy}), 32'h0);
        chk("reset_req_word", req_word, 32'h0);
        chk("reset_wdata", m_axi_wdata, 32'h0);
        chk("reset_timeout_count", 32'(timeout_count), 32'h0);
        rst = 1'b1;
        tick();
        chk("idle_no_pending_busy", 32'(busy), 32'h0);

        pr_request_pending = 1'b1;
        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Reset asserted while the request sits in WAIT.
        pr_request_pending = 1'b1;
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b1;
        m_axi_rdata   = 32'hDEAD_BEEF;
        req_ready     = 1'b1;
        seen = -1;
        for (int u = 0; u < 40 && seen < 0; u++) begin
            tick();
            if (req_valid) seen = u;
        end
        if (seen < 0) begin
            checks++;
            errors++;
            $display("FAIL rst_reach_req: got no req_valid expected one");
        end
        tick();
        tick();
        tick();
        chk("rst_busy_in_wait", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_async_valids", 32'({m_axi_arvalid, m_axi_rready, req_valid, m_axi_awvalid,
                                     m_axi_wvalid, m_axi_bready, busy}), 32'h0);
        chk("rst_async_req_word", req_word, 32'h0);
        chk("rst_async_wdata", m_axi_wdata, 32'h0);
        chk("rst_async_timeout_count", 32'(timeout_count), 32'h0);
        tick();
        tick();
        chk("rst_held_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        run_txn(vpost, 8);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
